change_dispense_ctrl: RTL and testbench

- Sequences payout of a change amount computed by the vending state machine.
- Breaks the amount greedily into 50/20/10/5/1 pieces and issues one dispense request per piece to the coin/note dispenser using a req/ack handshake.
- Skips denominations the dispenser reports as empty.
- Reports done, fault (stock-out or dispenser timeout) and progress back to the vending control and the display.

---
 rtl/change_dispense_ctrl.sv | 149 ++++++++++++++
 tb/tb_change_dispense_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/change_dispense_ctrl.sv
// Change payout sequencer: greedy 50/20/10/5/1 breakdown, one req/ack handshake
// per piece, skipping empty denominations, with done/fault/progress reporting.
module change_dispense_ctrl #(
  parameter int unsigned AMT_W       = 8,
  parameter int unsigned ACK_TIMEOUT = 255,
  parameter int unsigned GAP_CYCLES  = 2
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             start,
  input  logic [AMT_W-1:0] change_amount,
  input  logic             abort,
  input  logic [4:0]       inv_empty,
  input  logic             disp_ack,
  output logic             disp_req,
  output logic [2:0]       disp_denom,
  output logic             busy,
  output logic             done,
  output logic             fault,
  output logic [AMT_W-1:0] remaining,
  output logic [5:0]       piece_cnt
);

  localparam int unsigned TMR_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_REQ,
    S_GAP,
    S_DONE,
    S_FAULT
  } state_t;

  state_t           state;
  logic [TMR_W-1:0] timer;
  logic [GAP_W-1:0] gap_cnt;
  logic [2:0]       sel_code_c;

  // Denomination code to its value in amount units.
  function automatic logic [AMT_W-1:0] denom_value(input logic [2:0] code);
    case (code)
      3'd1:    return AMT_W'(1);
      3'd2:    return AMT_W'(5);
      3'd3:    return AMT_W'(10);
      3'd4:    return AMT_W'(20);
      3'd5:    return AMT_W'(50);
      default: return '0;
    endcase
  endfunction

  // Largest stocked denomination not exceeding what is still owed; 0 if none.
  always_comb begin
    sel_code_c = 3'd0;
    if (!inv_empty[4] && remaining >= AMT_W'(50))      sel_code_c = 3'd5;
    else if (!inv_empty[3] && remaining >= AMT_W'(20)) sel_code_c = 3'd4;
    else if (!inv_empty[2] && remaining >= AMT_W'(10)) sel_code_c = 3'd3;
    else if (!inv_empty[1] && remaining >= AMT_W'(5))  sel_code_c = 3'd2;
    else if (!inv_empty[0] && remaining >= AMT_W'(1))  sel_code_c = 3'd1;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= S_IDLE;
      disp_req   <= 1'b0;
      disp_denom <= 3'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fault      <= 1'b0;
      remaining  <= '0;
      piece_cnt  <= 6'd0;
      timer      <= '0;
      gap_cnt    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_SELECT;
            busy      <= 1'b1;
            remaining <= change_amount;
            piece_cnt <= 6'd0;
            fault     <= 1'b0;
          end
        end
        S_SELECT: begin
          if (remaining == '0) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else if (sel_code_c != 3'd0) begin
            state      <= S_REQ;
            disp_req   <= 1'b1;
            disp_denom <= sel_code_c;
            timer      <= '0;
          end else begin
            state <= S_FAULT;
            fault <= 1'b1;
          end
        end
        S_REQ: begin
          if (disp_ack) begin
            remaining  <= remaining - denom_value(disp_denom);
            if (piece_cnt != 6'd63) piece_cnt <= piece_cnt + 6'd1;
            disp_req   <= 1'b0;
            disp_denom <= 3'd0;
            gap_cnt    <= '0;
            state      <= (GAP_CYCLES > 0) ? S_GAP : S_SELECT;
          end else if (timer == TMR_LAST) begin
            disp_req   <= 1'b0;
            disp_denom <= 3'd0;
            fault      <= 1'b1;
            state      <= S_FAULT;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_LAST) state <= S_SELECT;
          else                     gap_cnt <= gap_cnt + GAP_W'(1);
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        S_FAULT: begin
          state <= S_FAULT;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase

      // Abort wins over any transition but keeps an ack taken this cycle.
      if (abort && state != S_IDLE) begin
        state      <= S_IDLE;
        busy       <= 1'b0;
        disp_req   <= 1'b0;
        disp_denom <= 3'd0;
        done       <= 1'b0;
        fault      <= fault;
      end
    end
  end

endmodule

// File: tb/tb_change_dispense_ctrl.sv
// Randomized scoreboard bench for change_dispense_ctrl with a greedy payout model.
module tb_change_dispense_ctrl;

  localparam int unsigned AMT_W  = 8;
  localparam int unsigned ACK_TO = 8;
  localparam int unsigned GAP    = 2;

  logic             sys_clk = 1'b0;
  logic             sys_rst_n;
  logic             start;
  logic [AMT_W-1:0] change_amount;
  logic             abort;
  logic [4:0]       inv_empty;
  logic             disp_ack;
  logic             disp_req;
  logic [2:0]       disp_denom;
  logic             busy;
  logic             done;
  logic             fault;
  logic [AMT_W-1:0] remaining;
  logic [5:0]       piece_cnt;

  change_dispense_ctrl #(
    .AMT_W      (AMT_W),
    .ACK_TIMEOUT(ACK_TO),
    .GAP_CYCLES (GAP)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .start        (start),
    .change_amount(change_amount),
    .abort        (abort),
    .inv_empty    (inv_empty),
    .disp_ack     (disp_ack),
    .disp_req     (disp_req),
    .disp_denom   (disp_denom),
    .busy         (busy),
    .done         (done),
    .fault        (fault),
    .remaining    (remaining),
    .piece_cnt    (piece_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int code;
    int rem;
  } piece_t;

  typedef struct {
    bit is_fault;
    int rem;
    int pcs;
  } end_t;

  piece_t piece_q[$];
  end_t   end_q[$];
  int     total = 0;
  int     bad = 0;
  bit     ack_en;
  int     ack_min;
  int     ack_max;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Greedy payout from the value list; records each piece and the final outcome.
  task automatic model_push(input int amt, input logic [4:0] inv);
    int vals[5] = '{50, 20, 10, 5, 1};
    int rem;
    int n;
    int pick;
    bit stuck;
    rem = amt;
    n = 0;
    stuck = 1'b0;
    while (rem > 0 && !stuck) begin
      pick = 0;
      for (int k = 0; k < 5; k++)
        if (pick == 0 && vals[k] <= rem && !inv[4-k]) pick = 5 - k;
      if (pick == 0) begin
        stuck = 1'b1;
      end else begin
        piece_q.push_back('{pick, rem});
        rem -= vals[5-pick];
        n++;
      end
    end
    end_q.push_back('{stuck, rem, (n > 63) ? 63 : n});
  endtask

  // Dispenser model: acks after a random delay, plus stray acks while no request.
  initial begin
    int cnt;
    int dly;
    cnt = 0;
    dly = 0;
    disp_ack = 1'b0;
    forever begin
      @(posedge sys_clk);
      #1;
      disp_ack = 1'b0;
      if (disp_req && ack_en) begin
        if (cnt == dly) begin
          disp_ack = 1'b1;
          cnt = 0;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
        dly = $urandom_range(ack_max, ack_min);
        disp_ack = ack_en && ($urandom_range(0, 7) == 0);
      end
    end
  end

  // Monitor: pops expectations whenever a piece is accepted or a payout ends.
  initial begin
    bit     prev_fault;
    piece_t p;
    end_t   e;
    prev_fault = 1'b0;
    forever begin
      @(negedge sys_clk);
      if (sys_rst_n) begin
        if (disp_req && disp_ack) begin
          if (piece_q.size() == 0) begin
            check("unexpected_piece", int'(disp_denom), 0);
          end else begin
            p = piece_q.pop_front();
            check("piece_denom", int'(disp_denom), p.code);
            check("piece_remaining", int'(remaining), p.rem);
          end
        end
        if (done || (fault && !prev_fault)) begin
          if (end_q.size() == 0) begin
            check("unexpected_end_done_fault", int'({done, fault}), 0);
          end else begin
            e = end_q.pop_front();
            check("end_kind_fault", int'(fault), int'(e.is_fault));
            check("end_remaining", int'(remaining), e.rem);
            check("end_piece_cnt", int'(piece_cnt), e.pcs);
            check("end_pieces_pending", piece_q.size(), 0);
          end
        end
      end
      prev_fault = fault;
    end
  end

  task automatic pulse_start(input int amt);
    @(negedge sys_clk);
    start = 1'b1;
    change_amount = AMT_W'(amt);
    @(negedge sys_clk);
    start = 1'b0;
  endtask

  task automatic wait_end(output bit timed_out);
    int n;
    n = 0;
    while (busy && !fault && n < 5000) begin
      @(negedge sys_clk);
      n++;
    end
    timed_out = (n >= 5000);
  endtask

  task automatic do_abort();
    @(negedge sys_clk);
    abort = 1'b1;
    @(negedge sys_clk);
    abort = 1'b0;
  endtask

  task automatic run_payout(input int amt, input logic [4:0] inv);
    bit to;
    inv_empty = inv;
    model_push(amt, inv);
    pulse_start(amt);
    wait_end(to);
    check("wait_end_expired", int'(to), 0);
    if (fault) do_abort();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_disp_req"}, int'(disp_req), 0);
    check({tag, "_disp_denom"}, int'(disp_denom), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_fault"}, int'(fault), 0);
    check({tag, "_remaining"}, int'(remaining), 0);
    check({tag, "_piece_cnt"}, int'(piece_cnt), 0);
  endtask

  initial begin
    bit   to;
    int   n;
    int   cnt;
    logic [4:0] inv;
    sys_rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    change_amount = '0;
    inv_empty = '0;
    ack_en = 1'b1;
    ack_min = 0;
    ack_max = 5;
    repeat (3) @(negedge sys_clk);
    check_all_zero("reset");
    sys_rst_n = 1'b1;
    @(negedge sys_clk);

    // 87 with full stock: 50,20,10,5,1,1 and two-edge start latency
    ack_min = 2;
    ack_max = 2;
    inv_empty = 5'b00000;
    model_push(87, 5'b00000);
    pulse_start(87);
    check("lat_req_after_1_edge", int'(disp_req), 0);
    check("busy_after_start", int'(busy), 1);
    @(negedge sys_clk);
    check("lat_req_after_2_edges", int'(disp_req), 1);
    wait_end(to);
    check("wait_end_expired", int'(to), 0);
    check("fault_after_87", int'(fault), 0);
    check("remaining_after_87", int'(remaining), 0);

    // zero amount: done on the second cycle, busy exactly two cycles, no request
    model_push(0, 5'b00000);
    pulse_start(0);
    check("zero_done_c1", int'(done), 0);
    check("zero_req_c1", int'(disp_req), 0);
    cnt = int'(busy);
    @(negedge sys_clk);
    check("zero_done_c2", int'(done), 1);
    check("zero_req_c2", int'(disp_req), 0);
    cnt += int'(busy);
    @(negedge sys_clk);
    check("zero_done_c3", int'(done), 0);
    cnt += int'(busy);
    check("zero_busy_cycles", cnt, 2);

    // 60 with the 50 empty: three 20s
    ack_min = 0;
    ack_max = 5;
    run_payout(60, 5'b10000);

    // stock-out, abort keeps fault, next start clears it
    run_payout(3, 5'b00001);
    check("stockout_busy_after_abort", int'(busy), 0);
    check("stockout_fault_kept", int'(fault), 1);
    check("stockout_remaining_kept", int'(remaining), 3);
    inv_empty = 5'b00000;
    model_push(7, 5'b00000);
    pulse_start(7);
    check("fault_cleared_by_start", int'(fault), 0);
    wait_end(to);
    check("wait_end_expired", int'(to), 0);

    // ack timeout: request stays up ACK_TO cycles then faults with nothing paid
    ack_en = 1'b0;
    end_q.push_back('{1'b1, 10, 0});
    pulse_start(10);
    n = 0;
    cnt = 0;
    while (!fault && n < 100) begin
      if (disp_req) cnt++;
      @(negedge sys_clk);
      n++;
    end
    check("timeout_req_cycles", cnt, int'(ACK_TO));
    check("timeout_fault", int'(fault), 1);
    check("timeout_req_dropped", int'(disp_req), 0);
    check("timeout_remaining", int'(remaining), 10);
    check("timeout_piece_cnt", int'(piece_cnt), 0);
    do_abort();
    ack_en = 1'b1;

    // abort coincident with the first ack: ack counted, no done
    ack_min = 1;
    ack_max = 1;
    piece_q.push_back('{4, 25});
    pulse_start(25);
    n = 0;
    while (!(disp_req && disp_ack) && n < 50) begin
      @(negedge sys_clk);
      n++;
    end
    check("abort_ack_seen", int'(disp_req && disp_ack), 1);
    abort = 1'b1;
    @(negedge sys_clk);
    abort = 1'b0;
    check("abort_remaining", int'(remaining), 5);
    check("abort_piece_cnt", int'(piece_cnt), 1);
    check("abort_busy", int'(busy), 0);
    check("abort_req", int'(disp_req), 0);
    repeat (3) @(negedge sys_clk);

    // asynchronous reset in the middle of a request
    ack_en = 1'b0;
    pulse_start(25);
    n = 0;
    while (!disp_req && n < 50) begin
      @(negedge sys_clk);
      n++;
    end
    check("rst_req_reached", int'(disp_req), 1);
    #2;
    sys_rst_n = 1'b0;
    #1;
    check_all_zero("midreq_reset");
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    ack_en = 1'b1;
    @(negedge sys_clk);

    // piece counter saturation: 200 ones
    ack_min = 0;
    ack_max = 0;
    run_payout(200, 5'b11110);
    check("sat_piece_cnt", int'(piece_cnt), 63);

    // randomized payouts
    ack_min = 0;
    ack_max = 5;
    for (int r = 0; r < 40; r++) begin
      inv = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) != 0) inv[0] = 1'b0;
      if (inv[4:1] == 4'b1111) inv[4] = 1'b0;
      run_payout(int'($urandom_range(0, 255)), inv);
    end

    repeat (5) @(negedge sys_clk);
    check("pieces_left_in_queue", piece_q.size(), 0);
    check("ends_left_in_queue", end_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
